// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences MEM-stage data-memory accesses (LB/LBU/LH/LHU/LW, SB/SH/SW).
// Byte/half requests become word-aligned cycles with byte enables; loads are lane-selected
// and sign/zero-extended. Optional macro ACCESS_TIMEOUT_EN bounds the wait for mem_ack_in
// to TIMEOUT_CYCLES ACCESS cycles and turns an expiry into an error response.
module mem_access_unit #(
  parameter int unsigned NB_DATA        = 32,
  parameter int unsigned NB_ADDR        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid_in,
  output logic               req_ready_out,
  input  logic               req_write_in,
  input  logic [1:0]         req_size_in,
  input  logic               req_unsigned_in,
  input  logic [NB_ADDR-1:0] req_addr_in,
  input  logic [NB_DATA-1:0] req_wdata_in,
  output logic               mem_en_out,
  output logic [3:0]         mem_we_out,
  output logic [NB_ADDR-1:0] mem_addr_out,
  output logic [NB_DATA-1:0] mem_wdata_out,
  input  logic [NB_DATA-1:0] mem_rdata_in,
  input  logic               mem_ack_in,
  output logic               resp_valid_out,
  output logic [NB_DATA-1:0] resp_rdata_out,
  output logic               resp_error_out,
  output logic               busy_out
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StError} state_t;

  state_t               state;
  logic                 write_q;
  logic [1:0]           size_q;
  logic                 unsigned_q;
  logic [NB_ADDR-1:0]   addr_q;
  logic [NB_DATA-1:0]   wdata_q;
  logic [NB_DATA-1:0]   rdata_q;

  logic                 bad_req;
  logic [1:0]           lane;
  logic [NB_DATA-1:0]   rdata_shift;
  logic [NB_DATA-1:0]   load_ext;
  logic [3:0]           we_sel;
  logic [NB_DATA-1:0]   wdata_rep;

`ifdef ACCESS_TIMEOUT_EN
  localparam int unsigned NbTo = $clog2(TIMEOUT_CYCLES + 1);
  logic [NbTo-1:0] to_cnt;
`endif

  // Classify the incoming request as illegal/misaligned.
  always_comb begin
    bad_req = 1'b0;
    case (req_size_in)
      2'b00:   bad_req = 1'b0;
      2'b01:   bad_req = req_addr_in[0];
      2'b10:   bad_req = |req_addr_in[1:0];
      default: bad_req = 1'b1;
    endcase
  end

  // Lane select and extension of the read word; stores return zero.
  always_comb begin
    lane        = addr_q[1:0];
    rdata_shift = mem_rdata_in >> {lane, 3'b000};
    load_ext    = mem_rdata_in;
    case (size_q)
      2'b00: load_ext = unsigned_q ? {{(NB_DATA-8){1'b0}}, rdata_shift[7:0]}
                                   : {{(NB_DATA-8){rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01: load_ext = unsigned_q ? {{(NB_DATA-16){1'b0}}, rdata_shift[15:0]}
                                   : {{(NB_DATA-16){rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = mem_rdata_in;
    endcase
    if (write_q) load_ext = '0;
  end

  // Byte enables and lane-replicated store data from the registered request.
  always_comb begin
    case (size_q)
      2'b00: begin
        we_sel    = 4'b0001 << lane;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        we_sel    = 4'b0011 << lane;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        we_sel    = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
    if (!write_q) we_sel = 4'b0000;
  end

  // Control FSM plus request/response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
`ifdef ACCESS_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (req_valid_in) begin
            write_q    <= req_write_in;
            size_q     <= req_size_in;
            unsigned_q <= req_unsigned_in;
            addr_q     <= req_addr_in;
            wdata_q    <= req_wdata_in;
            state      <= bad_req ? StError : StAccess;
`ifdef ACCESS_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        StAccess: begin
          if (mem_ack_in) begin
            rdata_q <= load_ext;
            state   <= StResp;
          end
`ifdef ACCESS_TIMEOUT_EN
          // Count value TIMEOUT_CYCLES-1 marks the last allowed no-ack cycle.
          else if (to_cnt == NbTo'(TIMEOUT_CYCLES - 1)) begin
            state <= StError;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        StResp:  state <= StIdle;
        StError: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Outputs decode directly from the registered state so reset clears them at once.
  always_comb begin
    req_ready_out  = (state == StIdle) && !reset;
    busy_out       = (state != StIdle);
    mem_en_out     = (state == StAccess);
    mem_we_out     = mem_en_out ? we_sel : 4'b0000;
    mem_addr_out   = mem_en_out ? {addr_q[NB_ADDR-1:2], 2'b00} : '0;
    mem_wdata_out  = mem_en_out ? wdata_rep : '0;
    resp_valid_out = (state == StResp) || (state == StError);
    resp_error_out = (state == StError);
    resp_rdata_out = (state == StResp) ? rdata_q : '0;
  end

endmodule
